button_conditioner: RTL and testbench

- Multi-channel successor to the single-button one-shot synchronizer; conditions N raw push-button/switch inputs for the processor datapath and control FSMs.
- Each channel has a 2-flop synchronizer, a debounce filter, a one-cycle press pulse, and an optional auto-repeat while the button is held.
- Channels are fully independent; the block sits between the board KEY/SW pins and any logic that consumes single-cycle commands.

---
 rtl/button_conditioner.sv | 155 +++++++++++++++
 tb/tb_button_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N-channel button synchronizer, debouncer, one-shot and auto-repeat
//
// Purpose: conditions raw asynchronous push-button/switch inputs into clean
// single-cycle command pulses. Each channel is independent:
//   Bi -> (optional invert) -> 2-flop synchronizer -> debounce filter -> press/repeat FSM
//
// Ports:
//   Clk    in   1  system clock, all state on rising edge
//   ResetN in   1  asynchronous active-low reset
//   Bi     in   N  raw asynchronous button inputs
//   Bo     out  N  one-cycle press and repeat pulses (registered)
//   Level  out  N  debounced synchronized level, 1 = pressed (registered)
//   Held   out  N  1 while a channel is in the auto-repeat phase (registered)

module button_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_RATE     = 8,
    parameter int INVERT          = 0
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic [N-1:0] Bi,
    output logic [N-1:0] Bo,
    output logic [N-1:0] Level,
    output logic [N-1:0] Held
);

    localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW        = $clog2(HOLD_SPAN + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] RD_LAST   = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HW-1:0] RR_LAST   = HW'(REPEAT_RATE - 1);
    localparam logic [HW-1:0] HOLD_MAX  = '1;
    localparam logic          REPEAT_EN = (REPEAT_DELAY > 0);
    localparam logic          INV       = (INVERT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_REPEATING
    } state_e;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic          s1_q, s2_q;
        logic          lvl_q, lvl_d;
        logic [DW-1:0] db_q, db_d;
        state_e        state_q, state_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          bo_q, bo_d;
        logic          held_q, held_d;

        // Inversion happens ahead of the synchronizer so reset value 0 always means released.
        always_ff @(posedge Clk or negedge ResetN) begin
            if (!ResetN) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= Bi[g] ^ INV;
                s2_q <= s1_q;
            end
        end

        // Debounce: level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            lvl_d = lvl_q;
            db_d  = '0;
            if (s2_q != lvl_q) begin
                if (db_q == DB_LAST) begin
                    lvl_d = ~lvl_q;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        end

        // State register.
        always_ff @(posedge Clk or negedge ResetN) begin
            if (!ResetN) begin
                lvl_q   <= 1'b0;
                db_q    <= '0;
                state_q <= ST_IDLE;
                hold_q  <= '0;
                bo_q    <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                lvl_q   <= lvl_d;
                db_q    <= db_d;
                state_q <= state_d;
                hold_q  <= hold_d;
                bo_q    <= bo_d;
                held_q  <= held_d;
            end
        end

        // Next state. The FSM looks at lvl_d so the press pulse lands on the same
        // edge Level rises, and a release on a repeat edge suppresses that pulse.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            if (!lvl_d) begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_PRESSED;
                        hold_d  = '0;
                    end
                    ST_PRESSED: begin
                        if (REPEAT_EN && hold_q == RD_LAST) begin
                            state_d = ST_REPEATING;
                            hold_d  = '0;
                        end else if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    ST_REPEATING: begin
                        if (hold_q == RR_LAST) begin
                            hold_d = '0;
                        end else if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                endcase
            end
        end

        // Outputs (registered next cycle through bo_q/held_q).
        always_comb begin
            bo_d   = 1'b0;
            held_d = (state_d == ST_REPEATING);
            if (lvl_d) begin
                case (state_q)
                    ST_IDLE:      bo_d = 1'b1;
                    ST_PRESSED:   bo_d = REPEAT_EN && (hold_q == RD_LAST);
                    ST_REPEATING: bo_d = (hold_q == RR_LAST);
                    default:      bo_d = 1'b0;
                endcase
            end
        end

        assign Bo[g]    = bo_q;
        assign Level[g] = lvl_q;
        assign Held[g]  = held_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed table and sequence bench for button_conditioner

module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] bi_a, bo_a, level_a, held_a;
    logic [3:0] bi_b, bo_b, level_b, held_b;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] bi;
        logic [3:0] bo;
        logic [3:0] level;
        logic [3:0] held;
    } vec_t;

    localparam int NVEC = 48;
    vec_t tbl [NVEC];

    // Auto-repeat instance: delay 20, rate 8.
    button_conditioner #(
        .N(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .INVERT(0)
    ) dut_a (
        .Clk(clk), .ResetN(rst_n), .Bi(bi_a), .Bo(bo_a), .Level(level_a), .Held(held_a)
    );

    // Active-low, no repeat instance.
    button_conditioner #(
        .N(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(8), .INVERT(1)
    ) dut_b (
        .Clk(clk), .ResetN(rst_n), .Bi(bi_b), .Bo(bo_b), .Level(level_b), .Held(held_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Hold ch2 of dut_a from edge 0, release so the first released sample is edge rel_t.
    task automatic run_hold(input string tag, input int rel_t, input int len);
        int         off;
        logic       lvl, hld, pls;
        for (int t = 0; t < len; t++) begin
            bi_a = (t < rel_t) ? 4'b0100 : 4'b0000;
            tick();
            off = t - 5;
            lvl = (t >= 5) && (t <= rel_t + 4);
            hld = lvl && (off >= 20);
            pls = lvl && ((off == 0) || ((off >= 20) && ((off - 20) % 8 == 0)));
            chk($sformatf("%s_bo_t%0d", tag, t), bo_a, {1'b0, pls, 2'b00});
            chk($sformatf("%s_level_t%0d", tag, t), level_a, {1'b0, lvl, 2'b00});
            chk($sformatf("%s_held_t%0d", tag, t), held_a, {1'b0, hld, 2'b00});
        end
    endtask

    initial begin
        logic [4:0] bounce;
        int         j;

        checks = 0;
        errors = 0;
        bounce = 5'b01101;

        // Clean press on ch0 (k=0..19), then bounce on ch1 (k=20..47).
        for (int k = 0; k < NVEC; k++) begin
            tbl[k].bi    = 4'b0000;
            tbl[k].bo    = 4'b0000;
            tbl[k].level = 4'b0000;
            tbl[k].held  = 4'b0000;
            if (k < 12) tbl[k].bi[0] = 1'b1;
            if (k >= 5 && k <= 16) tbl[k].level[0] = 1'b1;
            if (k == 5) tbl[k].bo[0] = 1'b1;
            j = k - 20;
            if (j >= 0 && j < 5) tbl[k].bi[1] = bounce[j];
            if (j >= 5 && j < 20) tbl[k].bi[1] = 1'b1;
            if (j >= 10 && j <= 24) tbl[k].level[1] = 1'b1;
            if (j == 10) tbl[k].bo[1] = 1'b1;
        end

        // Reset with all inputs held pressed.
        rst_n = 1'b0;
        bi_a  = 4'b1111;
        bi_b  = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_bo_a", bo_a, 4'b0000);
        chk("rst_level_a", level_a, 4'b0000);
        chk("rst_held_a", held_a, 4'b0000);
        chk("rst_bo_b", bo_b, 4'b0000);
        chk("rst_level_b", level_b, 4'b0000);
        chk("rst_held_b", held_b, 4'b0000);

        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("rstrel_bo_k%0d", k), bo_a, (k == 5) ? 4'b1111 : 4'b0000);
            chk($sformatf("rstrel_level_k%0d", k), level_a, (k >= 5) ? 4'b1111 : 4'b0000);
            chk($sformatf("rstrel_held_k%0d", k), held_a, 4'b0000);
        end
        bi_a = 4'b0000;
        for (int i = 0; i < 12; i++) tick();
        chk("rstrel_level_after_release", level_a, 4'b0000);
        chk("idle_level_b", level_b, 4'b0000);

        // Table: clean press, bounce rejection, releases without pulses.
        for (int k = 0; k < NVEC; k++) begin
            bi_a = tbl[k].bi;
            tick();
            chk($sformatf("tbl_bo_k%0d", k), bo_a, tbl[k].bo);
            chk($sformatf("tbl_level_k%0d", k), level_a, tbl[k].level);
            chk($sformatf("tbl_held_k%0d", k), held_a, tbl[k].held);
        end

        // Auto-repeat held past P+60, then release/repeat coincidence at P+28.
        run_hold("rep", 65, 76);
        run_hold("coin", 28, 42);

        // Active-low channel 3 held 100 cycles: one pulse, never Held.
        bi_a = 4'b0000;
        for (int t = 0; t < 110; t++) begin
            bi_b = (t < 100) ? 4'b0111 : 4'b1111;
            tick();
            chk($sformatf("inv_bo_t%0d", t), bo_b, (t == 5) ? 4'b1000 : 4'b0000);
            chk($sformatf("inv_held_t%0d", t), held_b, 4'b0000);
            chk($sformatf("inv_level_t%0d", t), level_b,
                (t >= 5 && t <= 104) ? 4'b1000 : 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
